// File: rtl/weight_mem.sv
// weight_mem: DEPTH-word signed weight store, streamed full-memory load.
// Define WMEM_CHECKSUM_EN to add the 16-bit ld_checksum output.
module weight_mem #(
    parameter  int DATA_W   = 8,
    parameter  int N_IN     = 8,
    parameter  int N_HIDDEN = 4,
    localparam int DEPTH    = N_HIDDEN * N_IN,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_start,
    input  logic signed [DATA_W-1:0] ld_data,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    output logic                     load_done,
    output logic                     loaded,
    input  logic        [ADDR_W-1:0] wmem_raddr,
    output logic signed [DATA_W-1:0] wmem_rdata
`ifdef WMEM_CHECKSUM_EN
    ,
    output logic        [15:0]       ld_checksum
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);

    logic        [1:0]        state;
    logic        [ADDR_W-1:0] wr_ptr;
    logic signed [DATA_W-1:0] mem [DEPTH];
    logic                     wr_en;
    logic                     in_range;
    logic                     start_acc;

    assign ld_ready  = (state == LOAD);
    assign load_done = (state == DONE);
    assign wr_en     = (state == LOAD) && ld_valid;
    assign start_acc = (state == IDLE) && load_start;
    assign in_range  = ({1'b0, wmem_raddr} < DEPTH_X);

    // Load sequencer: IDLE -> LOAD (DEPTH transfers) -> DONE pulse -> IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            wr_ptr <= '0;
            loaded <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_start) begin
                        state  <= LOAD;
                        wr_ptr <= '0;
                        loaded <= 1'b0;
                    end
                end
                LOAD: begin
                    if (ld_valid) begin
                        if (wr_ptr == LAST) begin
                            state  <= DONE;
                            loaded <= 1'b1;
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Weight array write port; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= ld_data;
        end
    end

    // Registered read port; a same-cycle write is seen only on the next read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wmem_rdata <= '0;
        end else if (in_range) begin
            wmem_rdata <= mem[wmem_raddr];
        end else begin
            wmem_rdata <= '0;
        end
    end

`ifdef WMEM_CHECKSUM_EN
    // Running sum of accepted words, sign-extended, modulo 2^16
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_checksum <= '0;
        end else if (start_acc) begin
            ld_checksum <= '0;
        end else if (wr_en) begin
            ld_checksum <= ld_checksum + 16'(ld_data);
        end
    end
`endif

endmodule

// File: tb/tb_weight_mem.sv
// tb_weight_mem: randomized load/read scenarios against an array model
// of the weight store and its load protocol.
module tb_weight_mem;

    localparam int DATA_W   = 8;
    localparam int N_IN     = 8;
    localparam int N_HIDDEN = 4;
    localparam int DEPTH    = N_IN * N_HIDDEN;
    localparam int ADDR_W   = $clog2(DEPTH);

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     load_start = 1'b0;
    logic signed [DATA_W-1:0] ld_data = '0;
    logic                     ld_valid = 1'b0;
    logic                     ld_ready;
    logic                     load_done;
    logic                     loaded;
    logic        [ADDR_W-1:0] wmem_raddr = '0;
    logic signed [DATA_W-1:0] wmem_rdata;
`ifdef WMEM_CHECKSUM_EN
    logic        [15:0]       ld_checksum;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    weight_mem #(
        .DATA_W  (DATA_W),
        .N_IN    (N_IN),
        .N_HIDDEN(N_HIDDEN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load_start(load_start),
        .ld_data   (ld_data),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .load_done (load_done),
        .loaded    (loaded),
        .wmem_raddr(wmem_raddr),
        .wmem_rdata(wmem_rdata)
`ifdef WMEM_CHECKSUM_EN
        ,
        .ld_checksum(ld_checksum)
`endif
    );

    // Reference model: expected array contents and the words to load
    logic signed [DATA_W-1:0] ref_mem   [DEPTH];
    logic signed [DATA_W-1:0] prev_mem  [DEPTH];
    logic signed [DATA_W-1:0] load_vals [DEPTH];
    logic signed [DATA_W-1:0] old_obs   [DEPTH];

    // Observations recorded by run_load
    int   r_writes, r_cycles, r_ready_cyc, r_ready_err;
    int   r_loaded_bad, r_done_early;
    logic r_done_end, r_loaded_end, r_ready_end;
    logic r_done_next, r_loaded_next, r_ready_next;
    logic [15:0] r_csum;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one full load. vmode: 0 valid held, 1 toggling, 2 random.
    // ign_cyc: cycle at which a stray load_start is pulsed (-1 none).
    task automatic run_load(input int vmode, input int ign_cyc);
        int   n;
        int   cyc;
        logic v;
        prev_mem     = ref_mem;
        r_ready_cyc  = 0;
        r_ready_err  = 0;
        r_loaded_bad = 0;
        r_done_early = 0;
        r_csum       = '0;
        ld_valid   = 1'b0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        n   = 0;
        cyc = 0;
        while (n < DEPTH && cyc < 2000) begin
            if (ld_ready === 1'b1) r_ready_cyc++;
            else r_ready_err++;
            if (loaded !== 1'b0) r_loaded_bad++;
            if (load_done !== 1'b0) r_done_early++;
            case (vmode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            ld_valid   = v;
            ld_data    = load_vals[n];
            wmem_raddr = ADDR_W'(n);
            if (cyc == ign_cyc) load_start = 1'b1;
            tick();
            load_start = 1'b0;
            if (v) begin
                old_obs[n] = wmem_rdata;
                ref_mem[n] = load_vals[n];
                n++;
            end
            cyc++;
        end
        r_writes = n;
        r_cycles = cyc;
        // Keep offering a junk word: nothing past the last word may land
        ld_valid = 1'b1;
        ld_data  = DATA_W'(85);
        r_done_end   = load_done;
        r_loaded_end = loaded;
        r_ready_end  = ld_ready;
`ifdef WMEM_CHECKSUM_EN
        r_csum = ld_checksum;
`endif
        tick();
        r_done_next   = load_done;
        r_loaded_next = loaded;
        r_ready_next  = ld_ready;
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic read_word(input int a,
                             output logic signed [DATA_W-1:0] d);
        wmem_raddr = ADDR_W'(a);
        tick();
        d = wmem_rdata;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++;
        if (ld_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ld_ready got=%b exp=0", ld_ready);
        end
        checks++;
        if (load_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_load_done got=%b exp=0", load_done);
        end
        checks++;
        if (loaded !== 1'b0) begin
            failures++;
            $display("FAIL reset_loaded got=%b exp=0", loaded);
        end
        checks++;
        if (wmem_rdata !== '0) begin
            failures++;
            $display("FAIL reset_rdata got=%0d exp=0", wmem_rdata);
        end
    endtask

    task automatic test_seq_load();
        logic signed [DATA_W-1:0] d;
        for (int i = 0; i < DEPTH; i++) load_vals[i] = DATA_W'(i);
        rst = 1'b0;
        run_load(0, -1);
        checks++;
        if (r_writes != DEPTH || r_cycles != DEPTH) begin
            failures++;
            $display("FAIL seq_writes got=%0d/%0d exp=%0d",
                     r_writes, r_cycles, DEPTH);
        end
        checks++;
        if (r_ready_cyc != DEPTH || r_ready_err != 0) begin
            failures++;
            $display("FAIL seq_ready_cycles got=%0d bad=%0d exp=%0d",
                     r_ready_cyc, r_ready_err, DEPTH);
        end
        checks++;
        if (r_done_early != 0 || r_done_end !== 1'b1 ||
            r_done_next !== 1'b0) begin
            failures++;
            $display("FAIL seq_done_pulse got=%0d,%b,%b exp=0,1,0",
                     r_done_early, r_done_end, r_done_next);
        end
        checks++;
        if (r_loaded_bad != 0 || r_loaded_end !== 1'b1 ||
            r_loaded_next !== 1'b1) begin
            failures++;
            $display("FAIL seq_loaded got=%0d,%b,%b exp=0,1,1",
                     r_loaded_bad, r_loaded_end, r_loaded_next);
        end
        checks++;
        if (r_ready_end !== 1'b0 || r_ready_next !== 1'b0) begin
            failures++;
            $display("FAIL seq_ready_after got=%b,%b exp=0,0",
                     r_ready_end, r_ready_next);
        end
        read_word(31, d);
        wmem_raddr = ADDR_W'(5);
        #1;
        checks++;
        if (wmem_rdata !== DATA_W'(31)) begin
            failures++;
            $display("FAIL latency_hold got=%0d exp=31", wmem_rdata);
        end
        tick();
        checks++;
        if (wmem_rdata !== DATA_W'(5)) begin
            failures++;
            $display("FAIL read_addr5 got=%0d exp=5", wmem_rdata);
        end
        read_word(31, d);
        checks++;
        if (d !== DATA_W'(31)) begin
            failures++;
            $display("FAIL read_addr31 got=%0d exp=31", d);
        end
        for (int a = 0; a < DEPTH; a++) begin
            read_word(a, d);
            checks++;
            if (d !== ref_mem[a]) begin
                failures++;
                $display("FAIL seq_readback addr=%0d got=%0d exp=%0d",
                         a, d, ref_mem[a]);
            end
        end
    endtask

    task automatic test_random_reads();
        int a;
        logic signed [DATA_W-1:0] d;
        for (int k = 0; k < 40; k++) begin
            a = $urandom_range(0, DEPTH - 1);
            read_word(a, d);
            checks++;
            if (d !== ref_mem[a]) begin
                failures++;
                $display("FAIL rand_read addr=%0d got=%0d exp=%0d",
                         a, d, ref_mem[a]);
            end
        end
    endtask

    task automatic test_toggle_load();
        logic signed [DATA_W-1:0] d;
        for (int i = 0; i < DEPTH; i++) load_vals[i] = DATA_W'($urandom);
        run_load(1, 7);
        checks++;
        if (r_writes != DEPTH || r_cycles != 2 * DEPTH - 1) begin
            failures++;
            $display("FAIL toggle_writes got=%0d/%0d exp=%0d/%0d",
                     r_writes, r_cycles, DEPTH, 2 * DEPTH - 1);
        end
        checks++;
        if (r_ready_err != 0 || r_loaded_bad != 0) begin
            failures++;
            $display("FAIL toggle_flags got=%0d,%0d exp=0,0",
                     r_ready_err, r_loaded_bad);
        end
        checks++;
        if (r_done_early != 0 || r_done_end !== 1'b1 ||
            r_done_next !== 1'b0) begin
            failures++;
            $display("FAIL toggle_done got=%0d,%b,%b exp=0,1,0",
                     r_done_early, r_done_end, r_done_next);
        end
        for (int a = 0; a < DEPTH; a++) begin
            read_word(a, d);
            checks++;
            if (d !== ref_mem[a]) begin
                failures++;
                $display("FAIL toggle_readback addr=%0d got=%0d exp=%0d",
                         a, d, ref_mem[a]);
            end
        end
    endtask

    task automatic test_random_valid();
        logic signed [DATA_W-1:0] d;
        for (int i = 0; i < DEPTH; i++) load_vals[i] = DATA_W'($urandom);
        run_load(2, -1);
        checks++;
        if (r_writes != DEPTH || r_ready_err != 0) begin
            failures++;
            $display("FAIL rvalid_writes got=%0d bad=%0d exp=%0d",
                     r_writes, r_ready_err, DEPTH);
        end
        checks++;
        if (r_done_end !== 1'b1 || r_loaded_end !== 1'b1) begin
            failures++;
            $display("FAIL rvalid_done got=%b,%b exp=1,1",
                     r_done_end, r_loaded_end);
        end
        for (int a = 0; a < DEPTH; a++) begin
            read_word(a, d);
            checks++;
            if (d !== ref_mem[a]) begin
                failures++;
                $display("FAIL rvalid_readback addr=%0d got=%0d exp=%0d",
                         a, d, ref_mem[a]);
            end
        end
    endtask

    task automatic test_collision();
        logic signed [DATA_W-1:0] d;
        for (int i = 0; i < DEPTH; i++) load_vals[i] = DATA_W'($urandom);
        load_vals[3] = DATA_W'(12);
        run_load(0, -1);
        for (int i = 0; i < DEPTH; i++) load_vals[i] = DATA_W'($urandom);
        load_vals[3]  = -DATA_W'(7);
        load_vals[20] = DATA_W'(99);
        run_load(0, -1);
        checks++;
        if (old_obs[3] !== DATA_W'(12)) begin
            failures++;
            $display("FAIL collide_old got=%0d exp=12", old_obs[3]);
        end
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (old_obs[i] !== prev_mem[i]) begin
                failures++;
                $display("FAIL collide_word addr=%0d got=%0d exp=%0d",
                         i, old_obs[i], prev_mem[i]);
            end
        end
        read_word(3, d);
        checks++;
        if (d !== -DATA_W'(7)) begin
            failures++;
            $display("FAIL collide_new got=%0d exp=-7", d);
        end
    endtask

    task automatic test_reset_midload();
        logic signed [DATA_W-1:0] d;
        logic signed [DATA_W-1:0] part [DEPTH];
        for (int i = 0; i < DEPTH; i++) part[i] = DATA_W'($urandom);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            ld_valid   = 1'b1;
            ld_data    = part[k];
            wmem_raddr = ADDR_W'(20);
            tick();
            ref_mem[k] = part[k];
        end
        checks++;
        if (wmem_rdata !== DATA_W'(99)) begin
            failures++;
            $display("FAIL midload_pre_rdata got=%0d exp=99", wmem_rdata);
        end
        ld_data = part[10];
        rst = 1'b1;
        #1;
        checks++;
        if (ld_ready !== 1'b0 || loaded !== 1'b0 || load_done !== 1'b0) begin
            failures++;
            $display("FAIL midload_rst_flags got=%b%b%b exp=000",
                     ld_ready, loaded, load_done);
        end
        checks++;
        if (wmem_rdata !== '0) begin
            failures++;
            $display("FAIL midload_rst_rdata got=%0d exp=0", wmem_rdata);
        end
        repeat (2) tick();
        rst      = 1'b0;
        ld_valid = 1'b0;
        read_word(20, d);
        checks++;
        if (d !== DATA_W'(99)) begin
            failures++;
            $display("FAIL midload_mem_kept got=%0d exp=99", d);
        end
        read_word(5, d);
        checks++;
        if (d !== part[5]) begin
            failures++;
            $display("FAIL midload_partial got=%0d exp=%0d", d, part[5]);
        end
        checks++;
        if (loaded !== 1'b0 || ld_ready !== 1'b0) begin
            failures++;
            $display("FAIL midload_abandon got=%b,%b exp=0,0",
                     loaded, ld_ready);
        end
        for (int i = 0; i < DEPTH; i++) load_vals[i] = DATA_W'($urandom);
        run_load(0, -1);
        checks++;
        if (r_writes != DEPTH || r_done_end !== 1'b1) begin
            failures++;
            $display("FAIL restart_load got=%0d,%b exp=%0d,1",
                     r_writes, r_done_end, DEPTH);
        end
        checks++;
        if (old_obs[0] !== part[0]) begin
            failures++;
            $display("FAIL restart_addr0 got=%0d exp=%0d", old_obs[0], part[0]);
        end
        for (int a = 0; a < DEPTH; a++) begin
            read_word(a, d);
            checks++;
            if (d !== ref_mem[a]) begin
                failures++;
                $display("FAIL restart_readback addr=%0d got=%0d exp=%0d",
                         a, d, ref_mem[a]);
            end
        end
    endtask

`ifdef WMEM_CHECKSUM_EN
    task automatic test_checksum();
        for (int i = 0; i < DEPTH; i++) load_vals[i] = -DATA_W'(1);
        run_load(0, -1);
        checks++;
        if (r_csum !== 16'hFFE0) begin
            failures++;
            $display("FAIL checksum_all_ones got=%h exp=ffe0", r_csum);
        end
        checks++;
        if (ld_checksum !== 16'hFFE0) begin
            failures++;
            $display("FAIL checksum_hold got=%h exp=ffe0", ld_checksum);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_seq_load();
        test_random_reads();
        test_toggle_load();
        test_random_valid();
        test_collision();
        test_reset_midload();
`ifdef WMEM_CHECKSUM_EN
        test_checksum();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/weight_mem.md
WEIGHT_MEM -- requirements
Module: weight_mem

Interface
REQ-001 SHALL have parameter DATA_W, default 8, weight word width in bits.
REQ-002 SHALL have parameter N_IN, default 8, input vector length (weights per neuron).
REQ-003 SHALL have parameter N_HIDDEN, default 4, neuron count; DEPTH = N_HIDDEN*N_IN words, ADDR_W = $clog2(DEPTH).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port load_start  input  1  one-cycle pulse that begins a full-memory load.
REQ-007 SHALL have port ld_data  input  DATA_W signed  load word.
REQ-008 SHALL have port ld_valid  input  1  ld_data is valid.
REQ-009 SHALL have port ld_ready  output  1  block accepts ld_data this cycle.
REQ-010 SHALL have port load_done  output  1  one-cycle pulse after the last word is written.
REQ-011 SHALL have port loaded  output  1  level; memory holds a complete load.
REQ-012 SHALL have port wmem_raddr  input  ADDR_W  read address from the MAC engine.
REQ-013 SHALL have port wmem_rdata  output  DATA_W signed  registered read data.

Function
REQ-014 SHALL store DEPTH words, with address h*N_IN+i holding the weight for neuron h, input i.
REQ-015 SHALL register wmem_rdata <= mem[wmem_raddr] every cycle: address at edge T, data valid after edge T+1; exactly 1-cycle latency, no enable.
REQ-016 SHALL drive wmem_rdata to 0 for wmem_raddr >= DEPTH.
REQ-017 SHALL return the pre-write (old) word when a read and a load write target the same address in the same cycle.
REQ-018 SHALL implement FSM states IDLE, LOAD, DONE.
REQ-019 IDLE: ld_ready=0; load_start=1 -> LOAD, write pointer cleared to 0, loaded cleared to 0 at the same edge.
REQ-020 LOAD: ld_ready=1; each cycle with ld_valid=1 writes ld_data to mem[wr_ptr] and increments wr_ptr; ld_valid=0 stalls with no write.
REQ-021 LOAD: the transfer at wr_ptr=DEPTH-1 -> DONE; no wrap-around, and no word beyond DEPTH-1 is accepted.
REQ-022 DONE: ld_ready=0, load_done=1 for exactly one cycle, loaded set to 1, then -> IDLE.
REQ-023 SHALL ignore load_start while in LOAD or DONE.
REQ-024 SHALL keep reads serviced in all states; data read during LOAD is mixed old/new and loaded=0 flags it.

Reset
REQ-025 On rst=1, asynchronously: state=IDLE, wr_ptr=0, ld_ready=0, load_done=0, loaded=0, wmem_rdata=0.
REQ-026 Memory array contents SHALL NOT be reset; a reset mid-load abandons the load, leaving loaded=0.
REQ-027 After rst deasserts, the first rising edge SHALL already perform a normal read/FSM update.

Configuration
REQ-028 Macro WMEM_CHECKSUM_EN, when defined, SHALL add output ld_checksum (16 bits): cleared on load_start, adding each accepted ld_data sign-extended modulo 2^16, held stable from load_done until the next load_start, 0 on reset.
REQ-029 Without WMEM_CHECKSUM_EN, port ld_checksum and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-030 Load 0..31 with ld_valid held high after load_start -> ld_ready high for 32 cycles, load_done pulses once on the cycle after word 31 is accepted, loaded=1.
REQ-031 After load, drive wmem_raddr=5 at edge T -> wmem_rdata=5 after edge T+1; wmem_raddr=31 -> 31.
REQ-032 Load with ld_valid toggling 1,0,1,0 -> exactly 32 writes, no skipped or duplicated address, load_done only after the 32nd transfer.
REQ-033 Assert rst at word 10 of a load -> ld_ready=0, loaded=0, wmem_rdata=0 immediately; a new load_start then restarts at address 0.
REQ-034 Read address 3 in the same cycle word 3 is written with value -7 over old value 12 -> returned data 12; the next read of address 3 returns -7.
REQ-035 With WMEM_CHECKSUM_EN, load 32 words of -1 -> ld_checksum=0xFFE0 at load_done.
